// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port of the beaver32rv core between the core
// load/store path (port C) and a debug/loader master (port D). One access is
// granted per cycle. Contention is resolved round-robin. A debug lock lets D
// run atomic bursts, and a starvation counter bounds how long that lock can
// hold off the core. Read data has a fixed latency of one cycle and is steered
// back to the port that issued the read.
//
// Handshake (both ports): a master raises x_req with x_we/x_addr/x_wdata/x_be
// and holds them stable until the cycle in which x_gnt=1. That cycle is the
// transfer, so writes commit at the rising edge that ends it. A master may drop
// x_req before it is granted, which cancels the request. A read granted in
// cycle N returns x_rvalid=1 with x_rdata in cycle N+1. Writes never raise
// x_rvalid.
//
// Parameters
//   ADDR_W    byte address width
//   DATA_W    data width (byte-enable width is DATA_W/8)
//   MAX_LOCK  consecutive locked D grants allowed before one C grant is forced
//             (must be >= 1)
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata/c_be   core request channel
//   d_req/d_we/d_addr/d_wdata/d_be   debug request channel
//   d_lock                    debug master asks for exclusive ownership
//   c_gnt, d_gnt              request accepted this cycle
//   c_rvalid/c_rdata          core read return
//   d_rvalid/d_rdata          debug read return
//   core_stall                c_req & ~c_gnt: core must hold PC/instruction
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be   memory command (0 when idle)
//   mem_rdata                 memory read data, one cycle after a read strobe
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                c_req,
  input  logic                c_we,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/8-1:0] c_be,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic                d_lock,

  output logic                c_gnt,
  output logic                d_gnt,
  output logic                c_rvalid,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   c_rdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                core_stall,

  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int LCW  = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] MAX_CNT = LCW'(MAX_LOCK);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic           last_d;    // 1: D was granted last, 0: C was granted last
  logic           locked;    // D holds the lock
  logic [LCW-1:0] lock_cnt;  // locked D grants since the lock (or last forced C)
  logic           rd_pend;   // a read was granted in the previous cycle
  logic           rd_owner;  // 0: that read belongs to C, 1: to D

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  logic lock_act;   // lock honoured this cycle
  logic cnt_full;   // D has used up its locked budget
  logic c_win;
  logic d_win;
  logic force_c;    // this cycle's C grant is the starvation-breaking one

  // The lock only counts while d_lock is still high: if d_lock falls during a
  // contention cycle, that same cycle already arbitrates round-robin.
  assign lock_act = locked & d_lock;
  assign cnt_full = (lock_cnt == MAX_CNT);

  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (c_req && d_req) begin
      if (lock_act) begin
        // D keeps the port until its budget is spent, then C gets one slot.
        if (cnt_full) c_win = 1'b1;
        else          d_win = 1'b1;
      end else if (last_d) begin
        c_win = 1'b1;
      end else begin
        d_win = 1'b1;
      end
    end else begin
      // A lone requester always wins, locked or not.
      c_win = c_req;
      d_win = d_req;
    end
  end

  // Nothing is granted while reset is held.
  assign c_gnt      = rst & c_win;
  assign d_gnt      = rst & d_win;
  assign force_c    = c_gnt & lock_act & cnt_full;
  assign core_stall = c_req & ~c_gnt;

  // ---------------------------------------------------------------------------
  // Memory command mux: driven from the granted port, all zero when idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (c_gnt) begin
      mem_en    = 1'b1;
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_be    = c_be;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
  end

  // ---------------------------------------------------------------------------
  // State update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d   <= 1'b1;   // so C wins the first contention after reset
      locked   <= 1'b0;
      lock_cnt <= '0;
      rd_pend  <= 1'b0;   // an in-flight read is dropped
      rd_owner <= 1'b0;
    end else begin
      if (c_gnt)      last_d <= 1'b0;
      else if (d_gnt) last_d <= 1'b1;

      if (!d_lock) begin
        locked   <= 1'b0;
        lock_cnt <= '0;
      end else if (d_gnt) begin
        // The grant that takes the lock is the first grant of the burst, so it
        // is counted as well.
        locked <= 1'b1;
        if (!cnt_full) lock_cnt <= lock_cnt + 1'b1;
      end else if (force_c) begin
        // C got its slot; D starts a fresh budget while the lock stays held.
        lock_cnt <= '0;
      end

      rd_pend  <= mem_en & ~mem_we;
      rd_owner <= d_gnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: memory data goes to the owner only; the other port sees 0.
  // ---------------------------------------------------------------------------
  assign c_rvalid = rst & rd_pend & ~rd_owner;
  assign d_rvalid = rst & rd_pend &  rd_owner;
  assign c_rdata  = c_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_one_grant: assert property (@(posedge clk) disable iff (!rst)
    !(c_gnt && d_gnt));

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
    lock_cnt <= MAX_CNT);

  a_be_width: assert property (@(posedge clk) disable iff (!rst)
    mem_en || (mem_be == {BE_W{1'b0}}));

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter. A behavioural model (grant rule, lock
// budget, word memory, read-return queue) predicts every output on every
// falling edge; the directed sequences additionally pin hand-computed values.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_LOCK = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              c_req, c_we, d_req, d_we, d_lock;
  logic [ADDR_W-1:0] c_addr, d_addr;
  logic [DATA_W-1:0] c_wdata, d_wdata;
  logic [BE_W-1:0]   c_be, d_be;
  logic              c_gnt, d_gnt, c_rvalid, d_rvalid, core_stall;
  logic [DATA_W-1:0] c_rdata, d_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_lock(d_lock),
    .c_gnt(c_gnt), .d_gnt(d_gnt),
    .c_rvalid(c_rvalid), .d_rvalid(d_rvalid),
    .c_rdata(c_rdata), .d_rdata(d_rdata),
    .core_stall(core_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Counters and compare helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h11111111 * i;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Grant rule, returned as {d, c}.
  function automatic logic [1:0] predict(input logic cr, input logic dr, input logic dl,
                                         input logic last_was_d, input logic lk,
                                         input int cnt);
    if (cr && dr) begin
      if (lk && dl) return (cnt < MAX_LOCK) ? 2'b10 : 2'b01;
      return last_was_d ? 2'b01 : 2'b10;
    end
    return {dr, cr};
  endfunction

  // ---------------------------------------------------------------------------
  // Memory behind the arbiter: command captured mid-cycle, applied at the edge.
  // ---------------------------------------------------------------------------
  logic [31:0] ram [16];
  initial begin
    logic s_en, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_be;
    for (int i = 0; i < 16; i++) ram[i] = init_word(i);
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_be;
      @(posedge clk);
      if (s_en) begin
        if (s_we) ram[s_addr[5:2]] = merge(ram[s_addr[5:2]], s_wdata, s_be);
        else      mem_rdata = ram[s_addr[5:2]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural model and scoreboard queue
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem [16];
  logic        m_last_d;
  logic        m_locked;
  int          m_cnt;
  logic [DATA_W-1:0] exp_q[$];
  logic              own_q[$];   // 0 = C, 1 = D

  initial begin
    logic [1:0] g;
    logic forced;
    for (int i = 0; i < 16; i++) m_mem[i] = init_word(i);
    m_last_d = 1'b1; m_locked = 1'b0; m_cnt = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_last_d = 1'b1; m_locked = 1'b0; m_cnt = 0;
        exp_q.delete(); own_q.delete();
      end else begin
        g = predict(c_req, d_req, d_lock, m_last_d, m_locked, m_cnt);
        forced = g[0] && m_locked && d_lock && (m_cnt == MAX_LOCK);
        if (g[0]) begin
          if (c_we) m_mem[c_addr[5:2]] = merge(m_mem[c_addr[5:2]], c_wdata, c_be);
          else begin exp_q.push_back(m_mem[c_addr[5:2]]); own_q.push_back(1'b0); end
          m_last_d = 1'b0;
        end
        if (g[1]) begin
          if (d_we) m_mem[d_addr[5:2]] = merge(m_mem[d_addr[5:2]], d_wdata, d_be);
          else begin exp_q.push_back(m_mem[d_addr[5:2]]); own_q.push_back(1'b1); end
          m_last_d = 1'b1;
        end
        if (!d_lock) begin
          m_locked = 1'b0; m_cnt = 0;
        end else if (g[1]) begin
          m_locked = 1'b1;
          if (m_cnt < MAX_LOCK) m_cnt = m_cnt + 1;
        end else if (forced) begin
          m_cnt = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] g;
    logic [31:0] e_data;
    logic e_own, e_valid;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk1("rst_c_gnt", c_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_c_rvalid", c_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk32("rst_c_rdata", c_rdata, 32'h0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        chk1("rst_stall", core_stall, c_req);
      end else begin
        g = predict(c_req, d_req, d_lock, m_last_d, m_locked, m_cnt);
        chk1("m_c_gnt", c_gnt, g[0]);
        chk1("m_d_gnt", d_gnt, g[1]);
        chk1("m_stall", core_stall, c_req && !g[0]);
        chk1("m_mem_en", mem_en, g[0] || g[1]);
        chk1("m_mem_we", mem_we, g[0] ? c_we : (g[1] ? d_we : 1'b0));
        chk32("m_mem_addr", mem_addr, g[0] ? c_addr : (g[1] ? d_addr : 32'h0));
        chk32("m_mem_wdata", mem_wdata, g[0] ? c_wdata : (g[1] ? d_wdata : 32'h0));
        chk32("m_mem_be", 32'(mem_be), g[0] ? 32'(c_be) : (g[1] ? 32'(d_be) : 32'h0));
        e_valid = (exp_q.size() != 0);
        e_data  = 32'h0;
        e_own   = 1'b0;
        if (e_valid) begin
          e_data = exp_q.pop_front();
          e_own  = own_q.pop_front();
        end
        chk1("m_c_rvalid", c_rvalid, e_valid && !e_own);
        chk1("m_d_rvalid", d_rvalid, e_valid && e_own);
        chk32("m_c_rdata", c_rdata, (e_valid && !e_own) ? e_data : 32'h0);
        chk32("m_d_rdata", d_rdata, (e_valid && e_own) ? e_data : 32'h0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_c(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
    c_req = req; c_we = we; c_addr = addr; c_wdata = wd; c_be = be;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input logic lk);
    d_req = req; d_we = we; d_addr = addr; d_wdata = wd; d_be = be; d_lock = lk;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------------
  initial begin
    logic exp_c;
    rst = 1'b0;
    drive_c(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    drive_d(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    repeat (3) step();
    // Requests present during reset must not be granted.
    @(negedge clk);
    chk1("reset_c_gnt", c_gnt, 1'b0);
    chk1("reset_d_gnt", d_gnt, 1'b0);
    chk1("reset_mem_en", mem_en, 1'b0);
    step();
    drive_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    rst = 1'b1;

    // Solo core read
    step();
    drive_c(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    @(negedge clk);
    chk1("solo_c_gnt", c_gnt, 1'b1);
    chk32("solo_mem_addr", mem_addr, 32'h10);
    chk1("solo_stall", core_stall, 1'b0);
    step();
    c_req = 1'b0;
    @(negedge clk);
    chk1("solo_c_rvalid", c_rvalid, 1'b1);
    chk32("solo_c_rdata", c_rdata, 32'hDEADBEEF);
    chk1("solo_d_rvalid", d_rvalid, 1'b0);

    // Solo debug write (leaves D as last granted)
    step();
    drive_d(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0);
    @(negedge clk);
    chk1("dwr_d_gnt", d_gnt, 1'b1);
    chk1("dwr_mem_we", mem_we, 1'b1);
    step();
    drive_d(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    chk1("dwr_no_rvalid", d_rvalid, 1'b0);

    // Contention round-robin: C, D, C, D
    step();
    drive_c(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    drive_d(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk1("rr_c_gnt", c_gnt, (i % 2) == 1);
      chk1("rr_d_gnt", d_gnt, (i % 2) == 0);
      chk1("rr_stall", core_stall, (i % 2) == 0);
      if (i == 2) chk32("rr_c_rdata", c_rdata, 32'hDEADBEEF);
      if (i == 3) chk32("rr_d_rdata", d_rdata, 32'h12345678);
      step();
    end
    drive_c(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);  // solo C: makes C last granted
    d_req = 1'b0;
    @(negedge clk);
    chk1("rr_tail_d_rvalid", d_rvalid, 1'b1);
    chk1("pre_lock_c_gnt", c_gnt, 1'b1);

    // Debug lock burst: D x8, C, D x8, C
    step();
    d_req = 1'b1; d_lock = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      exp_c = (i == 9) || (i == 18);
      @(negedge clk);
      chk1("lock_c_gnt", c_gnt, exp_c);
      chk1("lock_d_gnt", d_gnt, !exp_c);
      step();
    end
    c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;

    // Lock release after 3 locked D grants: next contention goes to C
    step();
    c_req = 1'b1; d_req = 1'b1; d_lock = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk1("rel_d_gnt", d_gnt, 1'b1);
      step();
    end
    d_lock = 1'b0;
    @(negedge clk);
    chk1("rel_c_gnt", c_gnt, 1'b1);
    chk1("rel_d_idle", d_gnt, 1'b0);
    step();
    c_req = 1'b0; d_req = 1'b0;

    // Write/read interleave
    step();
    drive_d(1'b1, 1'b1, 32'h4, 32'h000000AA, 4'b0001, 1'b0);
    @(negedge clk);
    chk1("wr_mem_we", mem_we, 1'b1);
    chk32("wr_mem_wdata", mem_wdata, 32'h000000AA);
    chk32("wr_mem_be", 32'(mem_be), 32'h1);
    step();
    drive_d(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive_c(1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    @(negedge clk);
    chk1("rd_mem_we", mem_we, 1'b0);
    chk1("rd_c_gnt", c_gnt, 1'b1);
    chk1("rd_no_d_rvalid", d_rvalid, 1'b0);
    step();
    c_req = 1'b0;
    @(negedge clk);
    chk1("rd_c_rvalid", c_rvalid, 1'b1);
    chk32("rd_c_rdata", c_rdata, 32'h111111AA);
    chk1("rd_d_rvalid", d_rvalid, 1'b0);

    // Async reset in the middle of a debug read return
    step();
    drive_d(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
    @(negedge clk);
    chk1("ar_d_gnt", d_gnt, 1'b1);
    step();
    d_req = 1'b0;
    chk1("ar_pre_rvalid", d_rvalid, 1'b1);
    chk32("ar_pre_rdata", d_rdata, 32'h12345678);
    #2 rst = 1'b0;
    #1;
    chk1("ar_rvalid_now", d_rvalid, 1'b0);
    chk32("ar_rdata_now", d_rdata, 32'h0);
    chk1("ar_mem_en_now", mem_en, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk1("ar_post_d_rvalid", d_rvalid, 1'b0);
      chk1("ar_post_c_rvalid", c_rvalid, 1'b0);
      step();
    end
    // First contention after reset goes to C
    c_req = 1'b1; d_req = 1'b1;
    @(negedge clk);
    chk1("ar_first_c_gnt", c_gnt, 1'b1);
    step();
    c_req = 1'b0; d_req = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory port of the beaver32rv core between the core load/store path (port C) and a debug/loader master (port D). It sits between the core and data memory. It grants one access per cycle using round-robin priority, routes 1-cycle-latency read data back to the issuing port, and supports a debug lock for atomic bursts. A starvation counter bounds how long a lock can block the core. `core_stall` tells the core to hold its PC and instruction while its request is pending.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width; byte-enable width is DATA_W/8.
- `MAX_LOCK`, default 8: maximum consecutive D grants under lock before one C grant is forced; must be ≥1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `c_req`, `d_req`  in  1  access request; held until granted.
- `c_we`, `d_we`  in  1  1 = write, 0 = read.
- `c_addr`, `d_addr`  in  ADDR_W  byte address.
- `c_wdata`, `d_wdata`  in  DATA_W  write data.
- `c_be`, `d_be`  in  DATA_W/8  byte enables.
- `d_lock`  in  1  debug requests exclusive ownership.
- `c_gnt`, `d_gnt`  out  1  request accepted this cycle.
- `c_rvalid`, `d_rvalid`  out  1  read data valid for that port.
- `c_rdata`, `d_rdata`  out  DATA_W  read data.
- `core_stall`  out  1  equals `c_req & ~c_gnt`.
- `mem_en`, `mem_we`  out  1  memory access strobe and write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_rdata`  in  DATA_W  memory read data, valid one cycle after `mem_en & ~mem_we`.

## Operation
- **Registered state:**
  - `last` (0 = C last granted, 1 = D last granted).
  - `locked` flag.
  - `lock_cnt`, sized $clog2(MAX_LOCK+1).
  - `rd_pend` and `rd_owner`.
- **Combinational grant:**
  - Only one requester: it is granted.
  - Both requesting, not locked: the port that was *not* granted last wins.
  - Locked: D wins while `d_req=1` and `lock_cnt<MAX_LOCK`. When `lock_cnt==MAX_LOCK` and `c_req=1`, C wins once.
  - While locked and `d_req=0`, C may be granted. Lock remains set.
- **Memory side:** `mem_*` are muxed from the granted port. `mem_en = c_gnt | d_gnt`. When idle, `mem_*` are driven to 0.
- **Lock handling:**
  - `locked` sets on a D grant with `d_lock=1`.
  - `locked` clears on any cycle with `d_lock=0`.
  - `lock_cnt` increments on each locked D grant, saturating at MAX_LOCK.
  - `lock_cnt` resets to 0 on a forced C grant or when `locked` clears.
- **Read return:**
  - A granted read sets `rd_pend=1` and `rd_owner` = granted port for the next cycle.
  - In that cycle, `x_rvalid = rd_pend & (rd_owner==x)` and `x_rdata = mem_rdata`.
  - The non-owner's `rdata` is 0.
  - Writes produce no `rvalid`.
- **Back-to-back:** a new grant may issue in the same cycle that a previous read returns. Throughput is one access per cycle.

## Timing
- **Reset (rst=0, async):**
  - `last=1`, so C wins the first contention.
  - `locked=0`, `lock_cnt=0`, `rd_pend=0`.
  - All `gnt`, `rvalid`, and `mem_en` outputs are forced 0 while `rst=0`. `rdata` outputs are 0.
- **Latency:**
  - Grant: 0 cycles from request (same cycle).
  - Read data: exactly 1 cycle after grant.
  - Write: committed at the grant edge.
- **Reset mid-read:** a read pending when `rst` asserts is dropped; no `rvalid` after reset release.
- **Simultaneous events:**
  - If `d_lock` falls in the same cycle as a contention, the lock is already ignored for that cycle's grant (normal round-robin applies).
  - A forced C grant sets `last=0`, so D wins the next contention. `locked` remains set if `d_lock` is still 1.
- **Handshake rule:** requester signals must be stable while `req=1` and `gnt=0`. Dropping `req` before grant is legal and cancels the request.

## Test plan
- **Reset then solo core read:** reset, then `c_req=1`, `c_we=0`, `c_addr=0x10`. Required: `c_gnt=1` same cycle, `mem_addr=0x10`, `core_stall=0`. Next cycle `c_rvalid=1`, `c_rdata=mem_rdata=0xDEADBEEF`, `d_rvalid=0`.
- **Contention round-robin:** `c_req` and `d_req` both held high for 4 cycles, no lock. Required: grants C, D, C, D; `core_stall=1` on cycles 2 and 4.
- **Debug lock burst:** `d_lock=1` with `d_req` and `c_req` both high, MAX_LOCK=8. Required: D granted 8 consecutive cycles, C granted on cycle 9, then D again. `lock_cnt` returns to 0 after the C grant.
- **Lock release:** drop `d_lock` after 3 locked D grants while both request. Required: the next grant follows round-robin, so C wins.
- **Write/read interleave:** D writes `0x000000AA` (be=4'b0001) to 0x4, then C reads 0x4 on the next cycle. Required: `mem_we=1` then 0, `c_rvalid` one cycle later, no `d_rvalid`.
- **Async reset mid-read:** assert `rst=0` half a cycle after a granted D read. Required: `d_rvalid=0` immediately and after reset release; outputs stay at reset values.
